ssd_scan_scheduler: RTL and testbench
=====================================

# ssd_scan_scheduler

Time-multiplexed scan scheduler for the board's eight-digit seven-segment display. It shares the display between two 16-bit game counters: the sun count on the right four digits and the zombies-killed count on the left four. Once per scan frame it snapshots both counters and converts them to BCD with a sequential double-dabble engine. It then drives one active-low anode and the matching segment pattern per digit slot. It sits between the game logic (`vga_bitchange`) and the top-level `An*`, `Ca..Cg` and `Dp` pins.

## Interface
- `DIGIT_TICKS`, default 100000: clock cycles per digit slot (1 ms at 100 MHz). Must be ≥ 40.
- `clk`  in  1  system clock (100 MHz).
- `reset_n`  in  1  asynchronous, active-low reset.
- `num_a`  in  16  right-group value (sun count); digits 0–3.
- `num_b`  in  16  left-group value (zombies killed); digits 4–7.
- `blank_lead`  in  1  1 = blank leading zeros within each group.
- `anode`  out  8  active-low digit enables; bit i drives An_i.
- `ssd_out`  out  7  active-low segments {a,b,c,d,e,f,g}; bit 6 = a.
- `dp`  out  1  decimal point, active low; held at 1 (off).
- `frame_done`  out  1  one-cycle pulse at the end of digit slot 7.

## Operation
- **Scan path**
  - `tick_cnt` counts 0..DIGIT_TICKS-1.
  - At `tick_cnt == DIGIT_TICKS-1`, `digit_idx` (3 bits) increments and wraps 7→0.
  - If `digit_idx` is 7 at that edge, `frame_done` pulses.
- **Digit mapping**
  - idx 0..3: units, tens, hundreds, thousands of A.
  - idx 4..7: the same for B.
- **Conversion FSM**: IDLE → CAPTURE → SHIFT_A → SHIFT_B → COMMIT → IDLE.
  - IDLE → CAPTURE on reset release (first frame) or on the cycle after `frame_done`.
  - CAPTURE (1 cycle): latch `num_a` and `num_b` into shadow registers.
  - SHIFT_A (16 cycles): a 20-bit BCD accumulator, cleared on entry. Each cycle, add 3 to every nibble ≥ 5, then shift left one bit, inserting the shadow MSB.
  - SHIFT_B (16 cycles): the same for B.
  - COMMIT (1 cycle): load both 4-digit display registers atomically and set `valid`.
- **Saturation**: if the 5th BCD nibble is nonzero (value > 9999), the group shows 9,9,9,9.
- **Leading-zero blanking**
  - With `blank_lead` = 1, a thousands/hundreds/tens digit is blanked when it and every higher digit in its group are zero.
  - The units digit is never blanked.
  - For a blanked slot, the anode is still asserted and `ssd_out` = 7'h7F.
- **Segment codes** (active low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
- **Inputs during conversion**: changes to `num_a`/`num_b` outside CAPTURE have no effect until the next frame.

## Timing
- **Reset values** (asynchronous, while `reset_n` = 0):
  - `anode` = 8'hFF, `ssd_out` = 7'h7F, `dp` = 1, `frame_done` = 0.
  - `tick_cnt` = 0, `digit_idx` = 0, `valid` = 0, display registers = 0, FSM = IDLE.
- **Latency**: CAPTURE to COMMIT is 34 cycles. `anode`/`ssd_out` are registered and reflect committed data one cycle after COMMIT.
- **Before first commit**: the scan counters run from reset release. `anode` stays 8'hFF until `valid` = 1.
- **Output update**: `anode`/`ssd_out` change only on `digit_idx` changes or one cycle after COMMIT. There are no glitches between slots.
- **Conversion window**: conversion (≤ 35 cycles) always completes inside digit slot 0 because `DIGIT_TICKS` ≥ 40. Slots 1–7 of a frame therefore display the data captured at that frame's start.
- **Reset mid-conversion**: the partial BCD result is discarded, all state returns to reset values, and conversion restarts after release.

## Test plan
1. **Reset**: hold `reset_n` low, then release with `num_a`=0, `num_b`=0, `DIGIT_TICKS`=50.
   - During reset: `anode`=FF, `ssd_out`=7F, `dp`=1.
   - `anode`=FE with `ssd_out`=0000001 within 36 cycles of release.
2. **Basic display**: `num_a`=1234, `num_b`=56, `blank_lead`=0.
   - Over one frame, slots 0..7 show 4,3,2,1,6,5,0,0.
   - `anode` walks FE,FD,FB,…,7F, one slot per 50 cycles.
   - `frame_done` pulses once per 400 cycles.
3. **Leading-zero blanking**: `blank_lead`=1, `num_a`=0, `num_b`=56.
   - Slot 0 shows 0; slots 1–3 show 7F.
   - Slots 4,5 show 6,5; slots 6,7 show 7F.
   - `anode` is still asserted in the blanked slots.
4. **Saturation**: `num_a`=16'hFFFF, `num_b`=10000.
   - Both groups show 9,9,9,9.
   - `num_b`=9999 shows 9,9,9,9 through the non-saturated path.
5. **Mid-frame change**: change `num_a` 7→8 during slot 3.
   - Slots 3–7 and the rest of the frame are unchanged.
   - The units digit shows 8 starting 35 cycles after the next `frame_done`.
6. **Async reset in SHIFT_B**: assert `reset_n` low.
   - Outputs go to reset values the same cycle, without a clock edge.
   - After release, the display shows the freshly captured values.

Source files
------------

// File: rtl/ssd_scan_scheduler.sv
// ssd_scan_scheduler: eight-digit seven-segment scan driver shared by two
// 16-bit counters. Each frame both counters are snapshotted, converted to BCD
// by a sequential double-dabble engine, and shown one digit per slot.
module ssd_scan_scheduler #(
   parameter int unsigned DIGIT_TICKS = 100000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] num_a,
   input  logic [15:0] num_b,
   input  logic        blank_lead,
   output logic [7:0]  anode,
   output logic [6:0]  ssd_out,
   output logic        dp,
   output logic        frame_done
);

   localparam int unsigned TW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(DIGIT_TICKS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CAPTURE,
      S_SHIFT_A,
      S_SHIFT_B,
      S_COMMIT
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] tick_q, tick_d;
   logic [2:0]    idx_q, idx_d;
   logic          start_q, start_d;
   logic [15:0]   shadow_a_q, shadow_a_d;
   logic [15:0]   shadow_b_q, shadow_b_d;
   logic [19:0]   acc_q, acc_d;
   logic [19:0]   bcd_a_q, bcd_a_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [15:0]   disp_a_q, disp_a_d;
   logic [15:0]   disp_b_q, disp_b_d;
   logic          valid_q, valid_d;
   logic [7:0]    anode_q, anode_d;
   logic [6:0]    seg_q, seg_d;

   logic          slot_end;
   logic [19:0]   step_res;
   logic [15:0]   grp;
   logic [1:0]    pos;
   logic [3:0]    digit;
   logic          blank3, blank2, blank1, blanked;

   // One double-dabble iteration: add 3 to every nibble >= 5, then shift in the next bit.
   function automatic logic [19:0] dd_step(input logic [19:0] acc, input logic in_bit);
      logic [19:0] adj;
      adj = acc;
      for (int unsigned i = 0; i < 5; i++) begin
         if (adj[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
         end
      end
      return {adj[18:0], in_bit};
   endfunction

   // Groups above 9999 (fifth BCD nibble set) display as 9999.
   function automatic logic [15:0] saturate(input logic [19:0] bcd);
      return (bcd[19:16] != 4'd0) ? 16'h9999 : bcd[15:0];
   endfunction

   // Active-low segment pattern {a,b,c,d,e,f,g} for one BCD digit.
   function automatic logic [6:0] seg_of(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b0000001;
         4'd1:    s = 7'b1001111;
         4'd2:    s = 7'b0010010;
         4'd3:    s = 7'b0000110;
         4'd4:    s = 7'b1001100;
         4'd5:    s = 7'b0100100;
         4'd6:    s = 7'b0100000;
         4'd7:    s = 7'b0001111;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0000100;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   assign slot_end   = (tick_q == TICK_LAST);
   assign frame_done = slot_end && (idx_q == 3'd7);
   assign dp         = 1'b1;
   assign anode      = anode_q;
   assign ssd_out    = seg_q;

   // Scan counters: tick within slot, digit slot index wrapping 7 -> 0.
   always_comb begin
      tick_d = slot_end ? '0 : tick_q + 1'b1;
      idx_d  = slot_end ? idx_q + 3'd1 : idx_q;
   end

   // Conversion FSM next-state and datapath.
   always_comb begin
      state_d    = state_q;
      start_d    = start_q;
      shadow_a_d = shadow_a_q;
      shadow_b_d = shadow_b_q;
      acc_d      = acc_q;
      bcd_a_d    = bcd_a_q;
      bit_cnt_d  = bit_cnt_q;
      disp_a_d   = disp_a_q;
      disp_b_d   = disp_b_q;
      valid_d    = valid_q;
      step_res   = '0;
      case (state_q)
         S_IDLE: begin
            if (start_q || frame_done) begin
               state_d = S_CAPTURE;
               start_d = 1'b0;
            end
         end
         S_CAPTURE: begin
            shadow_a_d = num_a;
            shadow_b_d = num_b;
            acc_d      = '0;
            bit_cnt_d  = '0;
            state_d    = S_SHIFT_A;
         end
         S_SHIFT_A: begin
            step_res   = dd_step(acc_q, shadow_a_q[15]);
            acc_d      = step_res;
            shadow_a_d = {shadow_a_q[14:0], 1'b0};
            bit_cnt_d  = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd15) begin
               // The accumulator is reused for B, so park A's result first.
               bcd_a_d   = step_res;
               acc_d     = '0;
               bit_cnt_d = '0;
               state_d   = S_SHIFT_B;
            end
         end
         S_SHIFT_B: begin
            step_res   = dd_step(acc_q, shadow_b_q[15]);
            acc_d      = step_res;
            shadow_b_d = {shadow_b_q[14:0], 1'b0};
            bit_cnt_d  = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd15) begin
               bit_cnt_d = '0;
               state_d   = S_COMMIT;
            end
         end
         S_COMMIT: begin
            disp_a_d = saturate(bcd_a_q);
            disp_b_d = saturate(acc_q);
            valid_d  = 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Display decode: built from next-state slot/data so the registered outputs
   // track a slot change or a commit with no extra cycle of lag.
   always_comb begin
      grp     = idx_d[2] ? disp_b_d : disp_a_d;
      pos     = idx_d[1:0];
      digit   = grp[{pos, 2'b00} +: 4];
      blank3  = blank_lead && (grp[15:12] == 4'd0);
      blank2  = blank3 && (grp[11:8] == 4'd0);
      blank1  = blank2 && (grp[7:4] == 4'd0);
      case (pos)
         2'd3:    blanked = blank3;
         2'd2:    blanked = blank2;
         2'd1:    blanked = blank1;
         default: blanked = 1'b0;
      endcase
      anode_d = anode_q;
      seg_d   = seg_q;
      if (slot_end || (state_q == S_COMMIT)) begin
         if (valid_d) begin
            anode_d = ~(8'h01 << idx_d);
            seg_d   = blanked ? 7'h7F : seg_of(digit);
         end else begin
            anode_d = 8'hFF;
            seg_d   = 7'h7F;
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         tick_q     <= '0;
         idx_q      <= '0;
         start_q    <= 1'b1;
         shadow_a_q <= '0;
         shadow_b_q <= '0;
         acc_q      <= '0;
         bcd_a_q    <= '0;
         bit_cnt_q  <= '0;
         disp_a_q   <= '0;
         disp_b_q   <= '0;
         valid_q    <= 1'b0;
         anode_q    <= 8'hFF;
         seg_q      <= 7'h7F;
      end else begin
         state_q    <= state_d;
         tick_q     <= tick_d;
         idx_q      <= idx_d;
         start_q    <= start_d;
         shadow_a_q <= shadow_a_d;
         shadow_b_q <= shadow_b_d;
         acc_q      <= acc_d;
         bcd_a_q    <= bcd_a_d;
         bit_cnt_q  <= bit_cnt_d;
         disp_a_q   <= disp_a_d;
         disp_b_q   <= disp_b_d;
         valid_q    <= valid_d;
         anode_q    <= anode_d;
         seg_q      <= seg_d;
      end
   end

endmodule

// File: tb/tb_ssd_scan_scheduler.sv
// Bench for ssd_scan_scheduler: directed and random frames checked against a
// decimal-arithmetic model of what each digit slot should show.
module tb_ssd_scan_scheduler;

   localparam int unsigned DT = 50;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] num_a, num_b;
   logic        blank_lead;
   logic [7:0]  anode;
   logic [6:0]  ssd_out;
   logic        dp;
   logic        frame_done;

   int n_assert = 0;
   int n_fail   = 0;

   localparam logic [6:0] SEG [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                       7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                       7'b0000000, 7'b0000100};

   ssd_scan_scheduler #(.DIGIT_TICKS(DT)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .num_a      (num_a),
      .num_b      (num_b),
      .blank_lead (blank_lead),
      .anode      (anode),
      .ssd_out    (ssd_out),
      .dp         (dp),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected pattern for decimal position k (0 = units) of a group value.
   function automatic logic [6:0] exp_seg(input logic [15:0] val, input int k, input bit bl);
      int unsigned v, p, d;
      v = (val > 16'd9999) ? 9999 : int'(val);
      p = 1;
      for (int i = 0; i < k; i++) p = p * 10;
      d = (v / p) % 10;
      if (bl && k > 0 && v < p) return 7'h7F;
      return SEG[d];
   endfunction

   task automatic wait_frame_done(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 1000 && !seen; i++) begin
         @(negedge clk);
         if (frame_done === 1'b1) seen = 1'b1;
      end
      chk({tag, "_fd_timeout"}, 32'(seen), 32'd1);
   endtask

   // Called at the negedge of a frame_done cycle; walks the next full frame.
   task automatic check_frame(input string tag, input logic [15:0] a, input logic [15:0] b,
                              input bit bl, input int chg_j, input logic [15:0] chg_val);
      int fd_cnt = 0;
      int fd_last = -1;
      int s;
      logic [7:0] ea;
      for (int j = 0; j < 8 * int'(DT); j++) begin
         @(negedge clk);
         if (j == chg_j) num_a = chg_val;
         if (frame_done === 1'b1) begin
            fd_cnt++;
            fd_last = j;
         end
         if (j % int'(DT) == 45) begin
            s  = j / int'(DT);
            ea = ~(8'h01 << s);
            chk($sformatf("%s_an%0d", tag, s), 32'(anode), 32'(ea));
            chk($sformatf("%s_seg%0d", tag, s), 32'(ssd_out),
                32'(exp_seg((s < 4) ? a : b, s % 4, bl)));
         end
      end
      chk({tag, "_fd_count"}, 32'(fd_cnt), 32'd1);
      chk({tag, "_fd_pos"}, 32'(fd_last), 32'(8 * DT - 1));
      chk({tag, "_dp"}, 32'(dp), 32'd1);
   endtask

   initial begin
      logic [15:0] ra, rb;
      bit rbl, found;

      // Reset state
      reset_n = 1'b0; num_a = '0; num_b = '0; blank_lead = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_anode", 32'(anode), 32'hFF);
      chk("rst_seg", 32'(ssd_out), 32'h7F);
      chk("rst_dp", 32'(dp), 32'd1);
      chk("rst_fd", 32'(frame_done), 32'd0);
      reset_n = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 36 && !found; i++) begin
         @(negedge clk);
         if (anode === 8'hFE) found = 1'b1;
      end
      chk("first_commit", 32'(found), 32'd1);
      chk("first_seg", 32'(ssd_out), 32'(7'b0000001));

      // Basic display
      num_a = 16'd1234; num_b = 16'd56; blank_lead = 1'b0;
      wait_frame_done("basic");
      check_frame("basic", 16'd1234, 16'd56, 1'b0, -1, '0);

      // Leading-zero blanking
      num_a = 16'd0; num_b = 16'd56; blank_lead = 1'b1;
      check_frame("blank", 16'd0, 16'd56, 1'b1, -1, '0);

      // Saturation and the 9999 boundary
      num_a = 16'hFFFF; num_b = 16'd10000; blank_lead = 1'b0;
      check_frame("sat", 16'hFFFF, 16'd10000, 1'b0, -1, '0);
      num_a = 16'd10; num_b = 16'd9999; blank_lead = 1'b1;
      check_frame("b9999", 16'd10, 16'd9999, 1'b1, -1, '0);

      // Mid-frame change of num_a during slot 3
      num_a = 16'd7; num_b = 16'd305; blank_lead = 1'b1;
      check_frame("mid", 16'd7, 16'd305, 1'b1, 3 * int'(DT) + 20, 16'd8);
      for (int j = 0; j < 35; j++) begin
         @(negedge clk);
         if (j == 33) chk("mid_old_units", 32'(ssd_out), 32'(SEG[7]));
         if (j == 34) chk("mid_new_units", 32'(ssd_out), 32'(SEG[8]));
      end
      wait_frame_done("post");
      check_frame("post", 16'd8, 16'd305, 1'b1, -1, '0);

      // Random frames
      for (int f = 0; f < 5; f++) begin
         ra = 16'($urandom_range(0, 65535));
         rb = (f % 2 == 0) ? 16'($urandom_range(0, 120)) : 16'($urandom_range(0, 65535));
         rbl = 1'($urandom);
         num_a = ra; num_b = rb; blank_lead = rbl;
         check_frame($sformatf("rnd%0d", f), ra, rb, rbl, -1, '0);
      end

      // Asynchronous reset while converting B
      num_a = 16'd4321; num_b = 16'd8765; blank_lead = 1'b0;
      for (int j = 0; j < 21; j++) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_anode", 32'(anode), 32'hFF);
      chk("arst_seg", 32'(ssd_out), 32'h7F);
      chk("arst_dp", 32'(dp), 32'd1);
      chk("arst_fd", 32'(frame_done), 32'd0);
      num_a = 16'd902; num_b = 16'd40;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 36 && !found; i++) begin
         @(negedge clk);
         if (anode === 8'hFE) found = 1'b1;
      end
      chk("arst_commit", 32'(found), 32'd1);
      chk("arst_units", 32'(ssd_out), 32'(exp_seg(16'd902, 0, 1'b0)));
      wait_frame_done("arst");
      check_frame("arst", 16'd902, 16'd40, 1'b0, -1, '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
